// File: rtl/rvr32_bus_arb.sv
// Two-master memory bus arbiter: instruction fetch (I) and load/store (D) share one
// memory port, with alternating priority on ties and a watchdog that ends stalled transfers.
module rvr32_bus_arb #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        i_valid,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,

  input  logic        d_valid,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic [31:0] d_rdata,
  output logic        d_ready,

  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,

  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arbState_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

  arbState_t   r_state;
  arbState_t   w_nextState;
  logic        r_lastGntD;
  logic [15:0] r_timeoutCnt;

  logic        w_grantValid;
  logic        w_done;
  logic        w_timeout;

  always_comb begin
    w_grantValid = 1'b0;
    case (r_state)
      GNT_I:   w_grantValid = i_valid;
      GNT_D:   w_grantValid = d_valid;
      default: w_grantValid = 1'b0;
    endcase
  end

  // A real completion always beats a timeout landing in the same cycle.
  assign w_done    = w_grantValid & mem_ready;
  assign w_timeout = w_grantValid & ~mem_ready & (r_timeoutCnt == TIMEOUT_LAST);

  always_comb begin
    w_nextState = r_state;
    mem_valid   = 1'b0;
    mem_addr    = 32'd0;
    mem_wdata   = 32'd0;
    mem_wstrb   = 4'd0;
    i_ready     = 1'b0;
    i_rdata     = 32'd0;
    d_ready     = 1'b0;
    d_rdata     = 32'd0;
    bus_err     = 1'b0;

    case (r_state)
      IDLE: begin
        if (d_valid && (!i_valid || !r_lastGntD)) begin
          w_nextState = GNT_D;
        end else if (i_valid) begin
          w_nextState = GNT_I;
        end
      end

      GNT_I: begin
        mem_valid = i_valid;
        mem_addr  = i_addr;
        if (w_done) begin
          i_ready = 1'b1;
          i_rdata = mem_rdata;
        end else if (w_timeout) begin
          i_ready = 1'b1;
          bus_err = 1'b1;
        end
        if (!i_valid || w_done || w_timeout) begin
          w_nextState = IDLE;
        end
      end

      GNT_D: begin
        mem_valid = d_valid;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        mem_wstrb = d_wstrb;
        if (w_done) begin
          d_ready = 1'b1;
          d_rdata = mem_rdata;
        end else if (w_timeout) begin
          d_ready = 1'b1;
          bus_err = 1'b1;
        end
        if (!d_valid || w_done || w_timeout) begin
          w_nextState = IDLE;
        end
      end

      default: w_nextState = IDLE;
    endcase
  end

  // The watchdog restarts at zero on every grant and only runs while the grant is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_lastGntD   <= 1'b0;
      r_timeoutCnt <= 16'd0;
    end else begin
      r_state <= w_nextState;
      if (w_done || w_timeout) begin
        r_lastGntD <= (r_state == GNT_D);
      end
      if ((r_state != IDLE) && (w_nextState == r_state)) begin
        r_timeoutCnt <= r_timeoutCnt + 16'd1;
      end else begin
        r_timeoutCnt <= 16'd0;
      end
    end
  end

endmodule

// File: tb/tb_rvr32_bus_arb.sv
// Directed bench for rvr32_bus_arb: arbitration, completion, abort, timeout and reset
// behaviour checked against hand-computed values.
module tb_rvr32_bus_arb;

  localparam int unsigned TIMEOUT = 4;

  logic        clk;
  logic        rst_n;
  logic        iValid;
  logic [31:0] iAddr;
  logic [31:0] iRdata;
  logic        iReady;
  logic        dValid;
  logic [31:0] dAddr;
  logic [31:0] dWdata;
  logic [3:0]  dWstrb;
  logic [31:0] dRdata;
  logic        dReady;
  logic        memValid;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [3:0]  memWstrb;
  logic [31:0] memRdata;
  logic        memReady;
  logic        busErr;

  int nCompared;
  int nMismatched;

  rvr32_bus_arb #(.TIMEOUT_CYC(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid   (iValid),
    .i_addr    (iAddr),
    .i_rdata   (iRdata),
    .i_ready   (iReady),
    .d_valid   (dValid),
    .d_addr    (dAddr),
    .d_wdata   (dWdata),
    .d_wstrb   (dWstrb),
    .d_rdata   (dRdata),
    .d_ready   (dReady),
    .mem_valid (memValid),
    .mem_addr  (memAddr),
    .mem_wdata (memWdata),
    .mem_wstrb (memWstrb),
    .mem_rdata (memRdata),
    .mem_ready (memReady),
    .bus_err   (busErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [31:0] ia,
                               input logic dv, input logic [31:0] da,
                               input logic [31:0] dwd, input logic [3:0] dws,
                               input logic mr, input logic [31:0] mrd);
    iValid   = iv;
    iAddr    = ia;
    dValid   = dv;
    dAddr    = da;
    dWdata   = dwd;
    dWstrb   = dws;
    memReady = mr;
    memRdata = mrd;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    nextCycle();
    rst_n = 1'b1;
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("rst memValid", 32'(memValid), 32'd0);
    checkOutput("rst iReady",   32'(iReady),   32'd0);
    checkOutput("rst dReady",   32'(dReady),   32'd0);
    checkOutput("rst busErr",   32'(busErr),   32'd0);
    checkOutput("rst memAddr",  memAddr,       32'd0);
    nextCycle();
    rst_n = 1'b1;

    // Single store, completed on the second granted cycle
    applyStimulus(0, 0, 1, 32'h100, 32'h11223344, 4'hF, 0, 0);
    #1;
    checkOutput("st req cycle memValid", 32'(memValid), 32'd0);
    nextCycle();
    checkOutput("st gnt1 memValid", 32'(memValid), 32'd1);
    checkOutput("st gnt1 memAddr",  memAddr,       32'h100);
    checkOutput("st gnt1 memWstrb", 32'(memWstrb), 32'hF);
    checkOutput("st gnt1 memWdata", memWdata,      32'h11223344);
    checkOutput("st gnt1 dReady",   32'(dReady),   32'd0);
    nextCycle();
    applyStimulus(0, 0, 1, 32'h100, 32'h11223344, 4'hF, 1, 32'hCAFE0001);
    #1;
    checkOutput("st done dReady",   32'(dReady),   32'd1);
    checkOutput("st done dRdata",   dRdata,        32'hCAFE0001);
    checkOutput("st done memWstrb", 32'(memWstrb), 32'hF);
    checkOutput("st done iReady",   32'(iReady),   32'd0);
    checkOutput("st done busErr",   32'(busErr),   32'd0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h99);
    #1;
    checkOutput("st idle memValid",   32'(memValid), 32'd0);
    checkOutput("idle memReady dRdy", 32'(dReady),   32'd0);
    nextCycle();
    checkOutput("idle memReady stays", 32'(memValid), 32'd0);

    // Tie after reset: D, then I, then D again
    doReset();
    applyStimulus(1, 32'h200, 1, 32'h300, 32'hA5A5A5A5, 4'h0, 0, 0);
    nextCycle();
    checkOutput("tie1 memAddr D", memAddr, 32'h300);
    applyStimulus(1, 32'h200, 1, 32'h300, 32'hA5A5A5A5, 4'h0, 1, 32'h55);
    #1;
    checkOutput("tie1 dReady",  32'(dReady), 32'd1);
    checkOutput("tie1 iReady",  32'(iReady), 32'd0);
    checkOutput("tie1 iRdata",  iRdata,      32'd0);
    nextCycle();
    applyStimulus(1, 32'h200, 0, 0, 32'hA5A5A5A5, 4'h0, 0, 0);
    #1;
    checkOutput("b2b gap memValid", 32'(memValid), 32'd0);
    nextCycle();
    checkOutput("tie1 I memAddr",  memAddr,        32'h200);
    checkOutput("tie1 I memWstrb", 32'(memWstrb),  32'd0);
    checkOutput("tie1 I memWdata", memWdata,       32'd0);
    applyStimulus(1, 32'h200, 0, 0, 32'hA5A5A5A5, 4'h0, 1, 32'hDEADBEEF);
    #1;
    checkOutput("fetch iReady", 32'(iReady), 32'd1);
    checkOutput("fetch iRdata", iRdata,      32'hDEADBEEF);
    checkOutput("fetch dRdata", dRdata,      32'd0);
    nextCycle();
    applyStimulus(1, 32'h210, 1, 32'h310, 0, 4'h0, 0, 0);
    nextCycle();
    checkOutput("tie2 memAddr D", memAddr, 32'h310);
    applyStimulus(1, 32'h210, 1, 32'h310, 0, 4'h0, 1, 32'h1);
    #1;
    checkOutput("tie2 dReady", 32'(dReady), 32'd1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // Fetch that never completes times out on the TIMEOUT-th granted cycle
    nextCycle();
    applyStimulus(1, 32'h400, 0, 0, 0, 0, 0, 32'h12345678);
    for (int k = 1; k <= int'(TIMEOUT); k++) begin
      nextCycle();
      checkOutput($sformatf("to cyc%0d busErr", k), 32'(busErr), 32'(k == int'(TIMEOUT)));
      checkOutput($sformatf("to cyc%0d iReady", k), 32'(iReady), 32'(k == int'(TIMEOUT)));
    end
    checkOutput("to iRdata", iRdata, 32'd0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("to after busErr",   32'(busErr),   32'd0);
    checkOutput("to after memValid", 32'(memValid), 32'd0);

    // Ready arriving in the timeout cycle is a normal completion
    applyStimulus(1, 32'h404, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k < int'(TIMEOUT); k++) begin
      nextCycle();
      checkOutput($sformatf("race cyc%0d busErr", k), 32'(busErr), 32'd0);
    end
    nextCycle();
    applyStimulus(1, 32'h404, 0, 0, 0, 0, 1, 32'h0BADF00D);
    #1;
    checkOutput("race iReady", 32'(iReady), 32'd1);
    checkOutput("race busErr", 32'(busErr), 32'd0);
    checkOutput("race iRdata", iRdata,      32'h0BADF00D);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // Fetch abort while a data request waits
    nextCycle();
    applyStimulus(1, 32'h500, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("abort req memValid", 32'(memValid), 32'd0);
    nextCycle();
    applyStimulus(1, 32'h500, 1, 32'h600, 32'h77, 4'h1, 0, 0);
    #1;
    checkOutput("abort gnt memValid", 32'(memValid), 32'd1);
    checkOutput("abort gnt memAddr",  memAddr,       32'h500);
    nextCycle();
    applyStimulus(0, 0, 1, 32'h600, 32'h77, 4'h1, 0, 0);
    #1;
    checkOutput("abort memValid", 32'(memValid), 32'd0);
    checkOutput("abort iReady",   32'(iReady),   32'd0);
    checkOutput("abort busErr",   32'(busErr),   32'd0);
    nextCycle();
    checkOutput("abort idle memValid", 32'(memValid), 32'd0);
    nextCycle();
    checkOutput("pend D memValid", 32'(memValid), 32'd1);
    checkOutput("pend D memAddr",  memAddr,       32'h600);
    applyStimulus(0, 0, 1, 32'h600, 32'h77, 4'h1, 1, 0);
    #1;
    checkOutput("pend D dReady", 32'(dReady), 32'd1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a data transfer
    nextCycle();
    applyStimulus(0, 0, 1, 32'h700, 32'h33, 4'h3, 0, 0);
    nextCycle();
    checkOutput("rstmid gnt memValid", 32'(memValid), 32'd1);
    applyStimulus(0, 0, 1, 32'h700, 32'h33, 4'h3, 1, 32'h44);
    #1;
    checkOutput("rstmid pre dReady", 32'(dReady), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rstmid memValid", 32'(memValid), 32'd0);
    checkOutput("rstmid dReady",   32'(dReady),   32'd0);
    checkOutput("rstmid memAddr",  memAddr,       32'd0);
    checkOutput("rstmid memWstrb", 32'(memWstrb), 32'd0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      nextCycle();
      checkOutput($sformatf("post rst%0d dReady", k), 32'(dReady), 32'd0);
      checkOutput($sformatf("post rst%0d busErr", k), 32'(busErr), 32'd0);
    end
    applyStimulus(0, 0, 1, 32'h800, 0, 4'h0, 0, 0);
    #1;
    checkOutput("post rst req memValid", 32'(memValid), 32'd0);
    nextCycle();
    checkOutput("post rst gnt memValid", 32'(memValid), 32'd1);
    checkOutput("post rst gnt memAddr",  memAddr,       32'h800);
    applyStimulus(0, 0, 1, 32'h800, 0, 4'h0, 1, 32'hF00D);
    #1;
    checkOutput("post rst dRdata", dRdata, 32'hF00D);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/rvr32_bus_arb.md
RVR32_BUS_ARB -- requirements
Module: rvr32_bus_arb

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255: number of granted cycles without mem_ready before a transfer is forcibly terminated; legal range 1..65535.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_valid  input  1  instruction-fetch request, held until i_ready.
REQ-005 i_addr  input  32  fetch word address; read-only master.
REQ-006 i_rdata  output  32  fetch read data, valid while i_ready=1.
REQ-007 i_ready  output  1  fetch transfer complete, one-cycle pulse.
REQ-008 d_valid  input  1  load/store unit request, held until d_ready.
REQ-009 d_addr  input  32  data word address, bits [1:0] already zero.
REQ-010 d_wdata  input  32  store data, byte lanes pre-aligned.
REQ-011 d_wstrb  input  4  byte write strobes; 4'b0000 means read.
REQ-012 d_rdata  output  32  data read word, valid while d_ready=1.
REQ-013 d_ready  output  1  data transfer complete, one-cycle pulse.
REQ-014 mem_valid/mem_addr/mem_wdata/mem_wstrb  output  1/32/32/4  shared memory request.
REQ-015 mem_rdata  input  32  memory read data, sampled when mem_ready=1.
REQ-016 mem_ready  input  1  memory completion; ignored while mem_valid=0.
REQ-017 bus_err  output  1  one-cycle pulse on timeout termination.

Function
REQ-018 FSM states IDLE, GNT_I, GNT_D; reset state IDLE.
REQ-019 IDLE: mem_valid=0, mem_addr/mem_wdata/mem_wstrb=0, i_ready=d_ready=0.
REQ-020 IDLE -> GNT_D if d_valid and not i_valid; IDLE -> GNT_I if i_valid and not d_valid.
REQ-021 Both valid in IDLE: grant the master not granted last (register last_gnt, reset value I, so D wins first tie).
REQ-022 Arbitration latency: exactly one cycle; mem_valid asserts the cycle after the request is seen in IDLE.
REQ-023 GNT_x: mem_valid=x_valid; mem_addr mux = x_addr; GNT_I drives mem_wstrb=0, mem_wdata=0; GNT_D drives d_wdata, d_wstrb.
REQ-024 GNT_x with mem_valid=1 and mem_ready=1: x_ready=1 combinationally same cycle, x_rdata=mem_rdata, next state IDLE, last_gnt<=x.
REQ-025 Non-granted master: ready=0, rdata=0; its request waits, never dropped.
REQ-026 GNT_x with x_valid=0 (master abort): mem_valid=0 that cycle, next state IDLE, no ready, last_gnt unchanged.
REQ-027 Timeout counter, 16 bits, cleared on entry to GNT_x, increments each GNT_x cycle with mem_ready=0.
REQ-028 Counter reaching TIMEOUT_CYC with mem_ready=0: x_ready=1, x_rdata=0, bus_err=1 for one cycle, next state IDLE.
REQ-029 mem_ready and timeout in same cycle: normal completion wins, bus_err=0.
REQ-030 mem_ready while in IDLE: ignored, no state change.
REQ-031 Back-to-back: after completion, IDLE for one cycle minimum before the next grant.

Reset
REQ-032 rst_n low: state IDLE, last_gnt=I, counter=0, all outputs 0 immediately (asynchronous).
REQ-033 Reset mid-transfer: transfer discarded, no ready or bus_err pulse after release.
REQ-034 First posedge after rst_n rises: normal arbitration; no pending state retained.

Verification
REQ-035 d_valid=1, d_addr=0x100, d_wstrb=4'hF, mem_ready at 2nd granted cycle -> mem_valid 1 cycle after request, d_ready pulse with mem_wstrb=4'hF, state IDLE next.
REQ-036 i_valid and d_valid asserted same cycle after reset -> D granted first, then I; a second tie grants D again (alternation).
REQ-037 i_valid=1, mem_ready never -> i_ready=1, i_rdata=0, bus_err=1 exactly TIMEOUT_CYC granted cycles after grant.
REQ-038 GNT_I, i_valid dropped before mem_ready -> mem_valid=0, IDLE next, no i_ready, pending d_valid granted next.
REQ-039 rst_n low during GNT_D with mem_ready pending -> outputs 0 at once; after release no d_ready/bus_err pulse.
REQ-040 mem_rdata=0xDEADBEEF on completion of fetch -> i_rdata=0xDEADBEEF during i_ready; d_rdata=0.
